gpio_ctrl: RTL and testbench

//  Parametrised memory-mapped GPIO peripheral on the core's io_* bus. Provides up to 32

---
 rtl/gpio_ctrl_pkg.sv | 22 ++
 rtl/gpio_ctrl_sync.sv | 68 ++++++
 rtl/gpio_ctrl.sv | 118 +++++++++++
 tb/tb_gpio_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_ctrl_pkg.sv
// gpio_ctrl_pkg: register map and bus helpers shared by the GPIO peripheral.
// The register offsets replace the `GPIO_REG_* constants of the shared core header.
package gpio_ctrl_pkg;

    // Register offsets, decoded from io_addr[4:2]
    typedef enum logic [2:0] {
        REG_OUT  = 3'd0,
        REG_DIR  = 3'd1,
        REG_IN   = 3'd2,
        REG_IE   = 3'd3,
        REG_EDGE = 3'd4,
        REG_PEND = 3'd5,
        REG_RSV6 = 3'd6,
        REG_RSV7 = 3'd7
    } gpio_reg_e;

    // Expand the 4 byte-lane enables into a 32-bit bit mask
    function automatic logic [31:0] lane_bits(input logic [3:0] mask);
        return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    endfunction

endpackage

// File: rtl/gpio_ctrl_sync.sv
// gpio_sync: one pin's input synchroniser, optionally followed by a debounce filter.
// Build option: define GPIO_DEBOUNCE_EN to add the debounce counter.
module gpio_sync
    import gpio_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic pin_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the asynchronous pad value through the synchroniser chain
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             synced;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;

    assign synced = sync_q[SYNC_STAGES-1];

    // Count consecutive cycles of disagreement; accept the new level after DEBOUNCE_CYCLES
    always_comb begin
        // NOTE: defaults first so no path through this block can infer a latch.
        cnt_d    = '0;
        stable_d = stable_q;
        if (synced != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = synced;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounce counter and filtered level
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign pin_o = stable_q;
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

    assign pin_o = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: memory-mapped GPIO with per-pin direction, synchronised inputs and
// edge-triggered write-1-to-clear interrupts. Build option: GPIO_DEBOUNCE_EN adds
// a debounce filter after each pin's synchroniser (see gpio_sync).
module gpio_ctrl
    import gpio_ctrl_pkg::*;
#(
    parameter int NUM_PINS        = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         io_addr,
    input  logic                io_op,
    input  logic [3:0]          io_mask,
    input  logic [31:0]         io_wdata,
    output logic [31:0]         io_rdata,
    input  logic [NUM_PINS-1:0] gpio_in,
    output logic [NUM_PINS-1:0] gpio_out,
    output logic [NUM_PINS-1:0] gpio_oe,
    output logic                irq
);

    gpio_reg_e           reg_sel;
    logic [31:0]         lane_w;
    logic [NUM_PINS-1:0] wdata_p, lane_p;
    logic [NUM_PINS-1:0] in_w;
    logic [NUM_PINS-1:0] out_q,  out_d;
    logic [NUM_PINS-1:0] dir_q,  dir_d;
    logic [NUM_PINS-1:0] ie_q,   ie_d;
    logic [NUM_PINS-1:0] edge_q, edge_d;
    logic [NUM_PINS-1:0] pend_q, pend_d;
    logic [NUM_PINS-1:0] prev_q;
    logic [NUM_PINS-1:0] pend_set, pend_clr;
    logic                unused_bits;

    // Only io_addr[4:2] is decoded and only the low NUM_PINS data bits are stored
    assign unused_bits = ^{io_addr[31:5], io_addr[1:0], io_wdata, lane_w};

    assign reg_sel = gpio_reg_e'(io_addr[4:2]);
    assign lane_w  = lane_bits(io_mask);
    assign wdata_p = io_wdata[NUM_PINS-1:0];
    assign lane_p  = lane_w[NUM_PINS-1:0];

    // Per-pin input conditioning
    for (genvar g = 0; g < NUM_PINS; g++) begin : g_pin
        gpio_sync #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_sync (
            .clk  (clk),
            .rst  (rst),
            .pin_i(gpio_in[g]),
            .pin_o(in_w[g])
        );
    end

    // Edge seen on IN this cycle in the configured direction, on enabled input pins
    assign pend_set = ((edge_q & in_w & ~prev_q) | (~edge_q & ~in_w & prev_q)) & ie_q & ~dir_q;

    // Register file next state: lane-masked writes, then W1C clear with set taking priority
    always_comb begin
        out_d    = out_q;
        dir_d    = dir_q;
        ie_d     = ie_q;
        edge_d   = edge_q;
        pend_clr = '0;
        if (io_op) begin
            case (reg_sel)
                REG_OUT:  out_d    = (out_q  & ~lane_p) | (wdata_p & lane_p);
                REG_DIR:  dir_d    = (dir_q  & ~lane_p) | (wdata_p & lane_p);
                REG_IE:   ie_d     = (ie_q   & ~lane_p) | (wdata_p & lane_p);
                REG_EDGE: edge_d   = (edge_q & ~lane_p) | (wdata_p & lane_p);
                REG_PEND: pend_clr = wdata_p & lane_p;
                default:  ;
            endcase
        end
        pend_d = (pend_q & ~pend_clr) | pend_set;
    end

    // Register file, previous-input copy for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= '0;
            dir_q  <= '0;
            ie_q   <= '0;
            edge_q <= '0;
            pend_q <= '0;
            prev_q <= '0;
        end else begin
            out_q  <= out_d;
            dir_q  <= dir_d;
            ie_q   <= ie_d;
            edge_q <= edge_d;
            pend_q <= pend_d;
            prev_q <= in_w;
        end
    end

    // Zero-latency read mux; reserved offsets read as zero
    always_comb begin
        io_rdata = '0;
        case (reg_sel)
            REG_OUT:  io_rdata = 32'(out_q);
            REG_DIR:  io_rdata = 32'(dir_q);
            REG_IN:   io_rdata = 32'(in_w);
            REG_IE:   io_rdata = 32'(ie_q);
            REG_EDGE: io_rdata = 32'(edge_q);
            REG_PEND: io_rdata = 32'(pend_q);
            default:  io_rdata = '0;
        endcase
    end

    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;
    assign irq      = |(pend_q & ie_q);

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: self-checking bench for gpio_ctrl (default build, SYNC_STAGES = 2).
// The reference model keeps the register contents and a history of the pad inputs:
// IN is the pad value from SYNC_STAGES-1 edges ago, and an edge is latched one edge later.
module tb_gpio_ctrl;

    localparam int NUM_PINS = 8;
    localparam int SYNC     = 2;
    localparam int DEB      = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [31:0]         io_addr = '0;
    logic                io_op = 1'b0;
    logic [3:0]          io_mask = '0;
    logic [31:0]         io_wdata = '0;
    logic [31:0]         io_rdata;
    logic [NUM_PINS-1:0] gpio_in = '0;
    logic [NUM_PINS-1:0] gpio_out;
    logic [NUM_PINS-1:0] gpio_oe;
    logic                irq;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    gpio_ctrl #(
        .NUM_PINS       (NUM_PINS),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .io_addr (io_addr),
        .io_op   (io_op),
        .io_mask (io_mask),
        .io_wdata(io_wdata),
        .io_rdata(io_rdata),
        .gpio_in (gpio_in),
        .gpio_out(gpio_out),
        .gpio_oe (gpio_oe),
        .irq     (irq)
    );

    // Reference model state
    logic [NUM_PINS-1:0] m_out, m_dir, m_ie, m_edge, m_pend;
    logic [NUM_PINS-1:0] in_hist[$];

    function automatic logic [NUM_PINS-1:0] merge(input logic [NUM_PINS-1:0] old_v,
                                                  input logic [31:0] d, input logic [3:0] m);
        logic [NUM_PINS-1:0] r;
        for (int i = 0; i < NUM_PINS; i++) r[i] = m[i/8] ? d[i] : old_v[i];
        return r;
    endfunction

    function automatic logic [31:0] exp_read(input int off);
        logic [31:0] r;
        r = '0;
        case (off)
            0: r[NUM_PINS-1:0] = m_out;
            1: r[NUM_PINS-1:0] = m_dir;
            2: r[NUM_PINS-1:0] = in_hist[SYNC-1];
            3: r[NUM_PINS-1:0] = m_ie;
            4: r[NUM_PINS-1:0] = m_edge;
            5: r[NUM_PINS-1:0] = m_pend;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic exp_irq();
        return |(m_pend & m_ie);
    endfunction

    // Apply one clock edge to the model using the values the DUT sees at that edge
    task automatic model_edge();
        logic [NUM_PINS-1:0] cur, prv, set, clr;
        if (rst) begin
            m_out = '0; m_dir = '0; m_ie = '0; m_edge = '0; m_pend = '0;
            in_hist.delete();
            for (int k = 0; k <= SYNC; k++) in_hist.push_back('0);
            return;
        end
        cur = in_hist[SYNC-1];
        prv = in_hist[SYNC];
        set = '0;
        clr = '0;
        for (int i = 0; i < NUM_PINS; i++)
            if (m_ie[i] && !m_dir[i] && cur[i] != prv[i] && cur[i] == m_edge[i]) set[i] = 1'b1;
        if (io_op) begin
            case (io_addr[4:2])
                3'd0: m_out  = merge(m_out,  io_wdata, io_mask);
                3'd1: m_dir  = merge(m_dir,  io_wdata, io_mask);
                3'd3: m_ie   = merge(m_ie,   io_wdata, io_mask);
                3'd4: m_edge = merge(m_edge, io_wdata, io_mask);
                3'd5: for (int i = 0; i < NUM_PINS; i++) clr[i] = io_mask[i/8] & io_wdata[i];
                default: ;
            endcase
        end
        m_pend = (m_pend & ~clr) | set;
        in_hist.push_front(gpio_in);
        void'(in_hist.pop_back());
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_write(input int off, input logic [31:0] d, input logic [3:0] m);
        io_op    = 1'b1;
        io_addr  = 32'(off) << 2;
        io_wdata = d;
        io_mask  = m;
        step();
        io_op   = 1'b0;
        io_mask = '0;
    endtask

    task automatic set_read(input int off);
        io_op   = 1'b0;
        io_addr = 32'(off) << 2;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int off = 0; off < 8; off++) begin
            set_read(off);
            n_tests++;
            if (io_rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_read off=%0d: got %h want 00000000", off, io_rdata);
            end
        end
        n_tests++;
        if (gpio_oe !== '0 || gpio_out !== '0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pins: oe=%h out=%h irq=%b want 00 00 0", gpio_oe, gpio_out, irq);
        end
    endtask

    task automatic test_masked_write();
        do_write(1, 32'hFFFF_FFFF, 4'b0001);
        set_read(1);
        n_tests++;
        if (io_rdata !== 32'h0000_00FF || gpio_oe !== 8'hFF) begin
            n_fail++;
            $display("FAIL dir_lane0: rdata=%h oe=%h want 000000ff ff", io_rdata, gpio_oe);
        end
        do_write(1, 32'h0000_0000, 4'b1110);
        set_read(1);
        n_tests++;
        if (io_rdata !== 32'h0000_00FF) begin
            n_fail++;
            $display("FAIL dir_masked_lanes: got %h want 000000ff", io_rdata);
        end
        do_write(0, 32'h0000_00A5, 4'hF);
        n_tests++;
        if (gpio_out !== 8'hA5) begin
            n_fail++;
            $display("FAIL out_a5: got %h want a5", gpio_out);
        end
        do_write(6, 32'hFFFF_FFFF, 4'hF);
        for (int off = 6; off < 8; off++) begin
            set_read(off);
            n_tests++;
            if (io_rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL reserved off=%0d: got %h want 00000000", off, io_rdata);
            end
        end
        // Read while a write to the same register is pending returns the old value
        io_op = 1'b1; io_addr = 32'h0; io_wdata = 32'h0000_003C; io_mask = 4'hF;
        #1;
        n_tests++;
        if (io_rdata !== 32'h0000_00A5) begin
            n_fail++;
            $display("FAIL read_during_write: got %h want 000000a5", io_rdata);
        end
        step();
        set_read(0);
        n_tests++;
        if (io_rdata !== 32'h0000_003C || gpio_out !== 8'h3C) begin
            n_fail++;
            $display("FAIL out_after_write: rdata=%h out=%h want 0000003c 3c", io_rdata, gpio_out);
        end
        do_write(2, 32'hFFFF_FFFF, 4'hF);
        set_read(2);
        n_tests++;
        if (io_rdata !== exp_read(2)) begin
            n_fail++;
            $display("FAIL in_readonly: got %h want %h", io_rdata, exp_read(2));
        end
        do_write(1, 32'h0, 4'hF);
    endtask

    task automatic test_sync_latency();
        gpio_in = '0;
        repeat (SYNC + 2) step();
        gpio_in[3] = 1'b1;
        step();
        set_read(2);
        n_tests++;
        if (io_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL sync_t1: got %h want 00000000", io_rdata);
        end
        step();
        set_read(2);
        n_tests++;
        if (io_rdata !== 32'h0000_0008) begin
            n_fail++;
            $display("FAIL sync_t2: got %h want 00000008", io_rdata);
        end
    endtask

    task automatic test_rising_irq();
        gpio_in = '0;
        repeat (SYNC + 2) step();
        do_write(3, 32'h08, 4'hF);
        do_write(4, 32'h08, 4'hF);
        gpio_in[3] = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            set_read(5);
            n_tests++;
            if (io_rdata !== exp_read(5) || irq !== exp_irq()) begin
                n_fail++;
                $display("FAIL rise_cycle%0d: pend=%h irq=%b want %h %b",
                         c, io_rdata, irq, exp_read(5), exp_irq());
            end
        end
        n_tests++;
        if (io_rdata !== 32'h08 || irq !== 1'b1) begin
            n_fail++;
            $display("FAIL rise_latched: pend=%h irq=%b want 00000008 1", io_rdata, irq);
        end
        gpio_in[3] = 1'b0;
        do_write(5, 32'h08, 4'b0000);
        set_read(5);
        n_tests++;
        if (io_rdata !== 32'h08) begin
            n_fail++;
            $display("FAIL w1c_masked: got %h want 00000008", io_rdata);
        end
        do_write(5, 32'h08, 4'hF);
        set_read(5);
        n_tests++;
        if (io_rdata !== 32'h0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL w1c_clear: pend=%h irq=%b want 00000000 0", io_rdata, irq);
        end
        repeat (SYNC + 2) step();
        set_read(5);
        n_tests++;
        if (io_rdata !== 32'h0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL falling_ignored: pend=%h irq=%b want 00000000 0", io_rdata, irq);
        end
    endtask

    task automatic test_collision();
        gpio_in[3] = 1'b1;
        step();
        step();
        do_write(5, 32'h08, 4'hF);
        set_read(5);
        n_tests++;
        if (io_rdata !== 32'h08 || irq !== 1'b1 || io_rdata !== exp_read(5)) begin
            n_fail++;
            $display("FAIL set_beats_clear: pend=%h irq=%b want 00000008 1", io_rdata, irq);
        end
        do_write(3, 32'h00, 4'hF);
        set_read(5);
        n_tests++;
        if (io_rdata !== 32'h08 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL ie_masks_only: pend=%h irq=%b want 00000008 0", io_rdata, irq);
        end
        do_write(5, 32'h08, 4'hF);
    endtask

    task automatic test_output_pin();
        do_write(1, 32'h08, 4'hF);
        do_write(3, 32'h08, 4'hF);
        gpio_in[3] = 1'b0;
        repeat (SYNC + 2) step();
        gpio_in[3] = 1'b1;
        repeat (SYNC + 2) step();
        set_read(2);
        n_tests++;
        if (io_rdata !== 32'h08) begin
            n_fail++;
            $display("FAIL outpin_in: got %h want 00000008", io_rdata);
        end
        set_read(5);
        n_tests++;
        if (io_rdata !== 32'h0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL outpin_no_edge: pend=%h irq=%b want 00000000 0", io_rdata, irq);
        end
        do_write(1, 32'h00, 4'hF);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            gpio_in  = NUM_PINS'($urandom);
            io_addr  = $urandom;
            io_op    = ($urandom_range(0, 9) < 3);
            io_wdata = $urandom;
            io_mask  = 4'($urandom);
            #1;
            n_tests++;
            if (io_rdata !== exp_read(int'(io_addr[4:2]))) begin
                n_fail++;
                $display("FAIL rand_read c=%0d off=%0d: got %h want %h",
                         c, io_addr[4:2], io_rdata, exp_read(int'(io_addr[4:2])));
            end
            n_tests++;
            if (gpio_out !== m_out || gpio_oe !== m_dir || irq !== exp_irq()) begin
                n_fail++;
                $display("FAIL rand_pins c=%0d: out=%h oe=%h irq=%b want %h %h %b",
                         c, gpio_out, gpio_oe, irq, m_out, m_dir, exp_irq());
            end
            step();
        end
        io_op   = 1'b0;
        io_mask = '0;
    endtask

    task automatic test_reset_mid();
        do_write(0, 32'h5A, 4'hF);
        do_write(3, 32'hFF, 4'hF);
        io_op = 1'b1; io_addr = 32'h0; io_wdata = 32'hFF; io_mask = 4'hF;
        rst = 1'b1;
        step();
        rst   = 1'b0;
        io_op = 1'b0;
        for (int off = 0; off < 6; off++) begin
            set_read(off);
            n_tests++;
            if (io_rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_mid off=%0d: got %h want 00000000", off, io_rdata);
            end
        end
        n_tests++;
        if (gpio_out !== '0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_pins: out=%h irq=%b want 00 0", gpio_out, irq);
        end
    endtask

    initial begin
        for (int k = 0; k <= SYNC; k++) in_hist.push_back('0);
        m_out = '0; m_dir = '0; m_ie = '0; m_edge = '0; m_pend = '0;
        @(negedge clk);
        test_reset();
        test_masked_write();
        test_sync_latency();
        test_rising_irq();
        test_collision();
        test_output_pin();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
